clock_scale_meter: RTL

CLOCK_SCALE_METER -- requirements
Module: clock_scale_meter

---
 rtl/clock_scale_meter_if.sv | 25 ++
 rtl/clock_scale_meter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/clock_scale_meter_if.sv
// Result bus of clock_scale_meter: measured value, saturation flag and a
// valid/ready handshake. The meter drives it through the master modport and
// the consumer uses the slave modport.
interface clock_scale_meter_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] meas_value;
    logic             meas_valid;
    logic             meas_ready;
    logic             meas_sat;

    modport master (
        output meas_value,
        output meas_valid,
        output meas_sat,
        input  meas_ready
    );

    modport slave (
        input  meas_value,
        input  meas_valid,
        input  meas_sat,
        output meas_ready
    );
endinterface

// File: rtl/clock_scale_meter.sv
// clock_scale_meter: measures the scale factor of a slow divided clock
// (clk_in) in clk cycles. Both clk_in edges are used, and each result is the
// edge-to-edge distance minus 1, so a divider programmed with scale S reads S.
// Optional feature: define CLOCK_SCALE_METER_TIMEOUT_EN to build the stall
// detector (stalled output, MEAS/ARM give up after TIMEOUT idle cycles).
module clock_scale_meter #(
    parameter int          WIDTH   = 32,
    parameter logic [31:0] TIMEOUT = 32'hFFFF_FFFE
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       clk_in,
    clock_scale_meter_if.master        meas_if,
    output logic                       overrun,
    output logic                       stalled
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] cnt_inc_s;

    // synchronizer pair, previous-level flop and registered edge pulse
    logic sync1_q, sync2_q, sync3_q, edge_q;

    logic             res_vld_s;
    logic [WIDTH-1:0] res_val_s;
    logic             load_s;
    logic             xfer_s;

    logic [WIDTH-1:0] meas_value_q;
    logic             meas_valid_q;
    logic             meas_sat_q;
    logic             overrun_q;

`ifdef CLOCK_SCALE_METER_TIMEOUT_EN
    // Compare at least 32 bits wide so a narrow counter never aliases TIMEOUT.
    localparam int CW = (WIDTH > 32) ? WIDTH : 32;
    logic [CW-1:0] cnt_ext_s;
    logic          timeout_hit_s;
    logic          stall_set_s;
    logic          stalled_q;

    assign cnt_ext_s     = CW'(cnt_q);
    assign timeout_hit_s = (cnt_ext_s == CW'(TIMEOUT));
`endif

    // Counter advances by one and sticks at all-ones.
    assign cnt_inc_s = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + WIDTH'(1));

    // Synchronize clk_in and register a both-edge pulse (3-cycle fixed latency).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= clk_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            edge_q  <= sync2_q ^ sync3_q;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, counter update and result generation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        res_vld_s = 1'b0;
        res_val_s = cnt_q;
`ifdef CLOCK_SCALE_METER_TIMEOUT_EN
        stall_set_s = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (en) begin
                    state_d = ST_ARM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (!en) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (edge_q) begin
                    // first edge only starts the period; nothing to report yet
                    state_d = ST_MEAS;
                    cnt_d   = '0;
                end else begin
`ifdef CLOCK_SCALE_METER_TIMEOUT_EN
                    if (timeout_hit_s) begin
                        stall_set_s = 1'b1;
                        cnt_d       = '0;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
`else
                    cnt_d = '0;
`endif
                end
            end
            ST_MEAS: begin
                if (!en) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (edge_q) begin
                    res_vld_s = 1'b1;
                    cnt_d     = '0;
                end else begin
`ifdef CLOCK_SCALE_METER_TIMEOUT_EN
                    if (timeout_hit_s) begin
                        stall_set_s = 1'b1;
                        state_d     = ST_ARM;
                        cnt_d       = '0;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
`else
                    cnt_d = cnt_inc_s;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign xfer_s = meas_valid_q & meas_if.meas_ready;
    assign load_s = res_vld_s & (~meas_valid_q | meas_if.meas_ready);

    // Output holding register with valid/ready handshake and sticky overrun.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meas_value_q <= '0;
            meas_valid_q <= 1'b0;
            meas_sat_q   <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            if (load_s) begin
                meas_value_q <= res_val_s;
                meas_sat_q   <= &res_val_s;
                meas_valid_q <= 1'b1;
            end else if (xfer_s) begin
                meas_valid_q <= 1'b0;
            end else begin
                meas_valid_q <= meas_valid_q;
            end

            if (res_vld_s && !load_s) begin
                overrun_q <= 1'b1;
            end else if (xfer_s) begin
                overrun_q <= 1'b0;
            end else begin
                overrun_q <= overrun_q;
            end
        end
    end

`ifdef CLOCK_SCALE_METER_TIMEOUT_EN
    // Stall flag: set on timeout, cleared by the next clk_in edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stalled_q <= 1'b0;
        end else if (edge_q) begin
            stalled_q <= 1'b0;
        end else if (stall_set_s) begin
            stalled_q <= 1'b1;
        end else begin
            stalled_q <= stalled_q;
        end
    end

    assign stalled = stalled_q;
`else
    assign stalled = 1'b0;
`endif

    assign meas_if.meas_value = meas_value_q;
    assign meas_if.meas_valid = meas_valid_q;
    assign meas_if.meas_sat   = meas_sat_q;
    assign overrun            = overrun_q;

endmodule
